// File: rtl/dbg_frame_bridge.sv
// Host-side debug-bus master: decodes 9-byte serial request frames into debug commands
// and answers each completed frame with a 5-byte status/read-data response.
module dbg_frame_bridge #(
  parameter int unsigned DONE_TIMEOUT = 1024,
  parameter int unsigned BYTE_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_done_i,
  output logic        busy_o
);

  localparam int unsigned DoneW = $clog2(DONE_TIMEOUT);
  localparam int unsigned IdleW = $clog2(BYTE_TIMEOUT);
  // Counters terminate when their next value would reach TIMEOUT-1.
  localparam logic [DoneW-1:0] DoneLast = DoneW'(DONE_TIMEOUT - 2);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(BYTE_TIMEOUT - 2);

  localparam logic [7:0] StatusOk      = 8'hA5;
  localparam logic [7:0] StatusBadCmd  = 8'hE1;
  localparam logic [7:0] StatusTimeout = 8'hEE;

  typedef enum logic [2:0] {
    StRx,
    StIssue,
    StWait,
    StRelease,
    StTx
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [DoneW-1:0]  done_cnt_q, done_cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       addr_sh_q, addr_sh_d;
  logic [31:0]       data_sh_q, data_sh_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_data_q, bus_data_d;
  logic [7:0]        status_q, status_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        tx_idx_q, tx_idx_d;

  logic rx_fire;
  logic cmd_valid;

  assign rx_fire   = rx_valid_i && (state_q == StRx);
  assign cmd_valid = (cmd_q >= 8'h01) && (cmd_q <= 8'h06);

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StRx;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      done_cnt_q <= '0;
      cmd_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      tx_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      done_cnt_q <= done_cnt_d;
      cmd_q      <= cmd_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    done_cnt_d = done_cnt_q;
    cmd_d      = cmd_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    tx_idx_d   = tx_idx_q;

    unique case (state_q)
      StRx: begin
        if (rx_fire) begin
          idle_cnt_d = '0;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd0) begin
            cmd_d = rx_data_i;
          end else if (byte_cnt_q <= 4'd4) begin
            addr_sh_d = {rx_data_i, addr_sh_q[31:8]};
          end else begin
            data_sh_d = {rx_data_i, data_sh_q[31:8]};
          end
          if (byte_cnt_q == 4'd8) begin
            byte_cnt_d = '0;
            if (cmd_valid) begin
              bus_addr_d = addr_sh_q;
              bus_data_d = {rx_data_i, data_sh_q[31:8]};
              state_d    = StIssue;
            end else begin
              // Unknown command: answer immediately, the core never sees it.
              status_d = StatusBadCmd;
              rdata_d  = '0;
              tx_idx_d = '0;
              state_d  = StTx;
            end
          end
        end else if (byte_cnt_q != 4'd0) begin
          if (idle_cnt_q == IdleLast) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        done_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (dbg_done_i) begin
          rdata_d  = dbg_data_i;
          status_d = StatusOk;
          state_d  = StRelease;
        end else if (done_cnt_q == DoneLast) begin
          rdata_d  = '0;
          status_d = StatusTimeout;
          state_d  = StRelease;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      StRelease: begin
        // Wait for the core to drop done so it cannot complete the next command early.
        if (!dbg_done_i) begin
          tx_idx_d = '0;
          state_d  = StTx;
        end
      end
      StTx: begin
        if (tx_ready_i) begin
          if (tx_idx_q == 3'd4) begin
            tx_idx_d   = '0;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = StRx;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      default: state_d = StRx;
    endcase
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == StTx) begin
      case (tx_idx_q)
        3'd0:    tx_data_o = status_q;
        3'd1:    tx_data_o = rdata_q[7:0];
        3'd2:    tx_data_o = rdata_q[15:8];
        3'd3:    tx_data_o = rdata_q[23:16];
        3'd4:    tx_data_o = rdata_q[31:24];
        default: tx_data_o = 8'h00;
      endcase
    end
  end

  // Command is decoded from state so an asynchronous reset clears it immediately.
  assign dbg_cmd_o  = ((state_q == StIssue) || (state_q == StWait)) ? cmd_q : 8'h00;
  assign dbg_addr_o = bus_addr_q;
  assign dbg_data_o = bus_data_q;
  assign rx_ready_o = (state_q == StRx);
  assign tx_valid_o = (state_q == StTx);
  assign busy_o     = (state_q != StRx);

endmodule

// File: tb/tb_dbg_frame_bridge.sv
// Directed bench for dbg_frame_bridge: queue-based transaction model plus a per-cycle checker.
module tb_dbg_frame_bridge;

  localparam int unsigned DoneTo = 16;
  localparam int unsigned ByteTo = 32;

  logic        clk;
  logic        rstn_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i;
  logic        dbg_done_i;
  logic        busy_o;

  dbg_frame_bridge #(
    .DONE_TIMEOUT (DoneTo),
    .BYTE_TIMEOUT (ByteTo)
  ) u_dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .dbg_cmd_o  (dbg_cmd_o),
    .dbg_addr_o (dbg_addr_o),
    .dbg_data_o (dbg_data_o),
    .dbg_data_i (dbg_data_i),
    .dbg_done_i (dbg_done_i),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } bus_t;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Core responder knobs.
  int          resp_delay = 0;
  int          done_hold  = 1;
  logic        core_mute  = 1'b0;
  logic [31:0] rd_data    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [7:0] status, input logic [31:0] data);
    exp_tx.push_back(status);
    for (int i = 0; i < 4; i++) exp_tx.push_back(data[8*i +: 8]);
  endtask

  task automatic expect_bus(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int len);
    bus_t b;
    b.cmd  = cmd;
    b.addr = addr;
    b.data = data;
    b.len  = len;
    exp_bus.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_in_time", rx_ready_o, 1'b1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || exp_tx.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", (n < 2000), 1'b1);
  endtask

  // Core model: raise done resp_delay cycles into WAIT for done_hold cycles.
  initial begin
    dbg_done_i = 1'b0;
    dbg_data_i = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      if (rstn_i && dbg_cmd_o != 8'h00 && !core_mute) begin
        repeat (resp_delay) begin
          @(posedge clk);
          #1;
        end
        @(posedge clk);
        #1;
        dbg_done_i = 1'b1;
        dbg_data_i = rd_data;
        repeat (done_hold) @(posedge clk);
        #1;
        dbg_done_i = 1'b0;
        dbg_data_i = 32'h0BAD_F00D;
      end
    end
  end

  // Per-cycle checker against the transaction queues.
  bus_t        cur;
  int          run_len   = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_tx   = 8'h00;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rstn_i) begin
      run_len    = 0;
      prev_stall = 1'b0;
      hold_addr  = '0;
      hold_data  = '0;
    end else begin
      check("rx_ready_vs_busy", rx_ready_o, !busy_o);
      if (tx_valid_o) check("tx_while_done_low", dbg_done_i, 1'b0);
      if (prev_stall) check("tx_held_while_stalled", {tx_valid_o, tx_data_o}, {1'b1, prev_tx});
      if (tx_valid_o && tx_ready_i) begin
        check("tx_byte_expected", (exp_tx.size() != 0), 1'b1);
        if (exp_tx.size() != 0) check("tx_byte", tx_data_o, exp_tx.pop_front());
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_tx    = tx_data_o;

      if (dbg_cmd_o != 8'h00) begin
        if (run_len == 0) begin
          check("bus_cmd_expected", (exp_bus.size() != 0), 1'b1);
          if (exp_bus.size() != 0) begin
            cur       = exp_bus.pop_front();
            hold_addr = cur.addr;
            hold_data = cur.data;
          end
        end
        check("bus_cmd", dbg_cmd_o, cur.cmd);
        check("bus_addr", dbg_addr_o, cur.addr);
        check("bus_data", dbg_data_o, cur.data);
        run_len++;
      end else begin
        if (run_len != 0) check("bus_cmd_cycles", run_len, cur.len);
        run_len = 0;
        check("idle_addr_held", dbg_addr_o, hold_addr);
        check("idle_data_held", dbg_data_o, hold_data);
      end
    end
  end

  int lat;

  initial begin
    rstn_i     = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    #12;
    check("rst_rx_ready", rx_ready_o, 1'b1);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cmd", dbg_cmd_o, 8'h00);
    check("rst_addr", dbg_addr_o, 32'h0);
    check("rst_data", dbg_data_o, 32'h0);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Halt with done one cycle after the command; pins the 3-cycle latency.
    resp_delay = 0; done_hold = 1; rd_data = 32'h0;
    expect_bus(8'h01, 32'h0, 32'h0, 2);
    expect_resp(8'hA5, 32'h0);
    send_frame(8'h01, 32'h0, 32'h0);
    lat = 0;
    while (!tx_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("halt_latency", lat, 3);
    wait_idle();

    // Register read.
    rd_data = 32'hDEAD_BEEF;
    expect_bus(8'h03, 32'h5, 32'h0, 2);
    expect_resp(8'hA5, 32'hDEAD_BEEF);
    send_frame(8'h03, 32'h5, 32'h0);
    check("rdreg_cmd_literal", dbg_cmd_o, 8'h03);
    check("rdreg_addr_literal", dbg_addr_o, 32'h5);
    wait_idle();

    // PC write with the TX sink stalled for 10 cycles.
    rd_data    = 32'h0;
    tx_ready_i = 1'b0;
    expect_bus(8'h06, 32'h0, 32'h0000_1000, 2);
    expect_resp(8'hA5, 32'h0);
    send_frame(8'h06, 32'h0, 32'h0000_1000);
    check("pcwr_data_literal", dbg_data_o, 32'h0000_1000);
    lat = 0;
    while (!tx_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pcwr_stall_byte", tx_data_o, 8'hA5);
    end
    @(posedge clk);
    #1;
    tx_ready_i = 1'b1;
    wait_idle();

    // Invalid command: no bus activity.
    expect_resp(8'hE1, 32'h0);
    send_frame(8'h09, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_idle();

    // Core never answers.
    core_mute = 1'b1;
    expect_bus(8'h02, 32'h3, 32'h0, DoneTo);
    expect_resp(8'hEE, 32'h0);
    send_frame(8'h02, 32'h3, 32'h0);
    wait_idle();
    core_mute = 1'b0;

    // Done in the expiry cycle still succeeds.
    resp_delay = DoneTo - 2; rd_data = 32'hCAFE_F00D;
    expect_bus(8'h01, 32'h0, 32'h0, DoneTo);
    expect_resp(8'hA5, 32'hCAFE_F00D);
    send_frame(8'h01, 32'h0, 32'h0);
    wait_idle();

    // Core holds done for several cycles; bridge waits in release.
    resp_delay = 1; done_hold = 3; rd_data = 32'h0102_0304;
    expect_bus(8'h05, 32'h1F, 32'h0, 3);
    expect_resp(8'hA5, 32'h0102_0304);
    send_frame(8'h05, 32'h1F, 32'h0);
    wait_idle();
    resp_delay = 0; done_hold = 1;

    // Partial frame abandoned, then a fresh frame.
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_cycles(ByteTo);
    check("discard_not_busy", busy_o, 1'b0);
    rd_data = 32'h55AA_0011;
    expect_bus(8'h04, 32'h7, 32'h1234_5678, 2);
    expect_resp(8'hA5, 32'h55AA_0011);
    send_frame(8'h04, 32'h7, 32'h1234_5678);
    wait_idle();

    // Byte arriving in the expiry cycle keeps the frame alive.
    rd_data = 32'h1357_9BDF;
    expect_bus(8'h02, 32'h0000_000A, 32'hA5A5_A5A5, 2);
    expect_resp(8'hA5, 32'h1357_9BDF);
    send_byte(8'h02); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h00);
    wait_cycles(ByteTo - 2);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    wait_idle();

    // Reset while waiting on the core.
    core_mute = 1'b1;
    expect_bus(8'h01, 32'h2, 32'h3, 0);
    send_frame(8'h01, 32'h2, 32'h3);
    repeat (3) @(posedge clk);
    #3;
    rstn_i = 1'b0;
    #1;
    check("rstwait_cmd", dbg_cmd_o, 8'h00);
    check("rstwait_busy", busy_o, 1'b0);
    check("rstwait_rx_ready", rx_ready_o, 1'b1);
    check("rstwait_tx_valid", tx_valid_o, 1'b0);
    @(posedge clk);
    #3;
    rstn_i    = 1'b1;
    core_mute = 1'b0;
    @(posedge clk);
    #1;
    rd_data = 32'h0;
    expect_bus(8'h01, 32'h0, 32'h0, 2);
    expect_resp(8'hA5, 32'h0);
    send_frame(8'h01, 32'h0, 32'h0);
    wait_idle();

    wait_cycles(5);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
